// File: rtl/rect_meter_pkg.sv
// Shared types and helpers for the rect_meter measurement block.
package rect_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } rm_state_t;

  localparam int unsigned SYNC_MIN = 2;
  localparam int unsigned SYNC_MAX = 4;
  localparam int unsigned SAT_W    = 64;

  // Unsigned add clamped to 2^w-1 (w <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{SAT_W{1'b0}}, 1'b1} << w) - 1'b1;
    if (sum > lim) begin
      return lim[SAT_W-1:0];
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/rect_meter_edge_sync.sv
// Synchroniser chain for the asynchronous probe input plus one-cycle
// delayed copy used for rise/fall detection.
module edge_sync
  import rect_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sig_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_sig_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_sig_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sig_s = r_sync[SYNC_STAGES-1];
  assign rise  = sig_s & ~r_sig_d;
  assign fall  = ~sig_s & r_sig_d;

endmodule

// File: rtl/rect_meter.sv
// Measures high time, low time and period of a rectangular input in clk
// cycles; one record per completed period over a valid/ready handshake.
module rect_meter
  import rect_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] th,
  output logic [CNT_W-1:0] tl,
  output logic [CNT_W-1:0] period,
  output logic             ovf,
  output logic             overrun
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN :
                                   (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             w_sig_s;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_th_inc;
  logic [CNT_W-1:0] w_tl_inc;
  logic [CNT_W-1:0] w_rec_th;
  logic [CNT_W-1:0] w_rec_tl;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_rec_per;
  logic             w_rec_ovf;

  rm_state_t        r_state;
  logic [CNT_W-1:0] r_th_c;
  logic [CNT_W-1:0] r_tl_c;
  logic             r_pub;
  logic [CNT_W-1:0] r_pub_th;
  logic [CNT_W-1:0] r_pub_tl;
  logic [CNT_W-1:0] r_pub_per;
  logic             r_pub_ovf;
  logic             r_valid;
  logic [CNT_W-1:0] r_th;
  logic [CNT_W-1:0] r_tl;
  logic [CNT_W-1:0] r_per;
  logic             r_ovf;
  logic             r_overrun;

  edge_sync #(
    .SYNC_STAGES(SYNC_N)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .sig_in(sig_in),
    .sig_s (w_sig_s),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  assign w_th_inc = CNT_W'(sat_add(SAT_W'(r_th_c), SAT_W'(1), CNT_W));
  assign w_tl_inc = CNT_W'(sat_add(SAT_W'(r_tl_c), SAT_W'(1), CNT_W));

  // Record contents for whichever publish can happen this cycle: a HIGH
  // timeout, a LOW timeout, or the normal end-of-period rise in LOW.
  always_comb begin
    w_rec_th = r_th_c;
    w_rec_tl = r_tl_c;
    if (r_state == HIGH) begin
      w_rec_th = w_th_inc;
      w_rec_tl = '0;
    end else if (!w_rise) begin
      w_rec_tl = w_tl_inc;
    end
    w_sum     = {1'b0, w_rec_th} + {1'b0, w_rec_tl};
    w_rec_per = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
    w_rec_ovf = w_sum[CNT_W] | (w_rec_th == CNT_MAX) | (w_rec_tl == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_th_c    <= '0;
      r_tl_c    <= '0;
      r_pub     <= 1'b0;
      r_pub_th  <= '0;
      r_pub_tl  <= '0;
      r_pub_per <= '0;
      r_pub_ovf <= 1'b0;
    end else begin
      r_pub <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
        r_th_c  <= '0;
        r_tl_c  <= '0;
      end else begin
        case (r_state)
          IDLE: r_state <= ARM;
          ARM: begin
            if (w_rise) begin
              r_th_c  <= CNT_ONE;
              r_tl_c  <= '0;
              r_state <= HIGH;
            end
          end
          HIGH: begin
            if (w_fall) begin
              r_tl_c  <= CNT_ONE;
              r_state <= LOW;
            end else if (w_sig_s) begin
              if (w_th_inc == CNT_MAX) begin
                r_pub     <= 1'b1;
                r_pub_th  <= w_rec_th;
                r_pub_tl  <= w_rec_tl;
                r_pub_per <= w_rec_per;
                r_pub_ovf <= w_rec_ovf;
                r_th_c    <= '0;
                r_tl_c    <= '0;
                r_state   <= ARM;
              end else begin
                r_th_c <= w_th_inc;
              end
            end
          end
          LOW: begin
            if (w_rise) begin
              r_pub     <= 1'b1;
              r_pub_th  <= w_rec_th;
              r_pub_tl  <= w_rec_tl;
              r_pub_per <= w_rec_per;
              r_pub_ovf <= w_rec_ovf;
              r_th_c    <= CNT_ONE;
              r_tl_c    <= '0;
              r_state   <= HIGH;
            end else if (!w_sig_s) begin
              if (w_tl_inc == CNT_MAX) begin
                r_pub     <= 1'b1;
                r_pub_th  <= w_rec_th;
                r_pub_tl  <= w_rec_tl;
                r_pub_per <= w_rec_per;
                r_pub_ovf <= w_rec_ovf;
                r_th_c    <= '0;
                r_tl_c    <= '0;
                r_state   <= ARM;
              end else begin
                r_tl_c <= w_tl_inc;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // A pending record is only replaced when it is accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_th      <= '0;
      r_tl      <= '0;
      r_per     <= '0;
      r_ovf     <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_pub) begin
      if (!r_valid || meas_ready) begin
        r_valid <= 1'b1;
        r_th    <= r_pub_th;
        r_tl    <= r_pub_tl;
        r_per   <= r_pub_per;
        r_ovf   <= r_pub_ovf;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && meas_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign meas_valid = r_valid;
  assign th         = r_th;
  assign tl         = r_tl;
  assign period     = r_per;
  assign ovf        = r_ovf;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_rect_meter.sv
// Self-checking bench for rect_meter: waveforms described as run lengths,
// expected records derived from those run lengths.
module tb_rect_meter;

  localparam int unsigned CW   = 4;
  localparam int unsigned SS   = 2;
  localparam int          MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sig_in;
  logic          meas_valid;
  logic          meas_ready;
  logic [CW-1:0] th;
  logic [CW-1:0] tl;
  logic [CW-1:0] period;
  logic          ovf;
  logic          overrun;

  rect_meter #(
    .CNT_W      (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .th        (th),
    .tl        (tl),
    .period    (period),
    .ovf       (ovf),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int th;
    int tl;
    int per;
    int ovf;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   rmode    = 2;
  int   pend     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected record for a high run h and low run l (timeouts pass h or l as MAXV).
  task automatic push(input int h, input int l);
    rec_t r;
    int   sum;
    sum   = h + l;
    r.th  = h;
    r.tl  = l;
    r.per = (sum > MAXV) ? MAXV : sum;
    r.ovf = (sum > MAXV || h >= MAXV || l >= MAXV) ? 1 : 0;
    exp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (meas_valid) pend++;
    else pend = 0;
    case (rmode)
      0: meas_ready = 1'b1;
      1: meas_ready = (pend >= 2) || ($urandom_range(0, 1) == 1);
      default: ;
    endcase
  endtask

  task automatic run(input logic level, input int n);
    sig_in = level;
    repeat (n) tick();
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (!rst && meas_valid && meas_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 1, 0);
      end else begin
        r = exp_q.pop_front();
        check("rec_th", 64'(th), 64'(r.th));
        check("rec_tl", 64'(tl), 64'(r.tl));
        check("rec_period", 64'(period), 64'(r.per));
        check("rec_ovf", 64'(ovf), 64'(r.ovf));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int c0;
    int h;
    int l;
    rst        = 1'b1;
    en         = 1'b0;
    sig_in     = 1'b0;
    meas_ready = 1'b0;
    rmode      = 2;
    repeat (3) tick();
    check("rst_valid", 64'(meas_valid), 0);
    check("rst_th", 64'(th), 0);
    check("rst_tl", 64'(tl), 0);
    check("rst_period", 64'(period), 0);
    check("rst_ovf", 64'(ovf), 0);
    check("rst_overrun", 64'(overrun), 0);
    rst = 1'b0;
    tick();

    // Square 3/5 with latency measurement on the rise that closes the first period.
    rmode = 0;
    en    = 1'b1;
    run(0, 4);
    run(1, 3);
    run(0, 5);
    push(3, 5);
    sig_in = 1'b1;
    lat    = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (meas_valid && lat == 0) lat = k;
    end
    check("latency", 64'(lat), 64'(SS + 2));
    run(0, 5);
    push(6, 5);
    for (int i = 0; i < 4; i++) begin
      run(1, 3);
      run(0, 5);
      push(3, 5);
    end
    run(1, 3);
    run(0, 4);
    en = 1'b0;
    repeat (8) tick();
    check("drain_square", 64'(exp_q.size()), 0);

    // Consumer stall: first record held, later ones dropped.
    rmode      = 2;
    meas_ready = 1'b0;
    en         = 1'b1;
    run(0, 4);
    push(3, 5);
    run(1, 3);
    repeat (3) begin
      run(0, 5);
      run(1, 3);
    end
    run(0, 6);
    check("stall_valid", 64'(meas_valid), 1);
    check("stall_th", 64'(th), 3);
    check("stall_overrun", 64'(overrun), 1);
    meas_ready = 1'b1;
    rmode      = 0;
    en         = 1'b0;
    repeat (6) tick();
    check("drain_stall", 64'(exp_q.size()), 0);
    check("overrun_sticky", 64'(overrun), 1);

    // 1-cycle pulses pending under stall, then reset while valid.
    rmode      = 2;
    meas_ready = 1'b0;
    en         = 1'b1;
    run(0, 4);
    repeat (3) begin
      run(1, 1);
      run(0, 1);
    end
    run(0, 4);
    check("pulse_pending_valid", 64'(meas_valid), 1);
    check("pulse_pending_th", 64'(th), 1);
    check("pulse_pending_period", 64'(period), 2);
    rst = 1'b1;
    en  = 1'b0;
    tick();
    check("midrst_valid", 64'(meas_valid), 0);
    check("midrst_th", 64'(th), 0);
    check("midrst_tl", 64'(tl), 0);
    check("midrst_period", 64'(period), 0);
    check("midrst_overrun", 64'(overrun), 0);
    rst = 1'b0;
    tick();

    rmode = 0;
    en    = 1'b1;
    run(0, 4);
    run(1, 1);
    repeat (5) begin
      run(0, 1);
      push(1, 1);
      run(1, 1);
    end
    run(0, 4);
    en = 1'b0;
    repeat (8) tick();
    check("drain_pulses", 64'(exp_q.size()), 0);
    check("pulses_overrun", 64'(overrun), 0);

    // Timeouts on a stuck level, restart from ARM, and period clamp.
    en = 1'b1;
    run(0, 3);
    push(MAXV, 0);
    run(1, 20);
    run(0, 4);
    run(1, 4);
    run(0, 4);
    push(4, 4);
    run(1, 3);
    push(3, MAXV);
    run(0, 20);
    run(1, 10);
    run(0, 9);
    push(10, 9);
    run(1, 2);
    run(0, 2);
    push(2, 2);
    run(1, 2);
    run(0, 3);
    en = 1'b0;
    repeat (8) tick();
    check("drain_timeout", 64'(exp_q.size()), 0);

    // Ready pulses exactly on the cycle the next record loads.
    rmode      = 2;
    meas_ready = 1'b0;
    en         = 1'b1;
    run(0, 4);
    run(1, 3);
    run(0, 5);
    push(3, 5);
    run(1, 4);
    run(0, 4);
    push(4, 4);
    sig_in = 1'b1;
    c0     = cyc;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (cyc == c0 + 4) begin
        check("same_cycle_valid", 64'(meas_valid), 1);
        check("same_cycle_th", 64'(th), 4);
        check("same_cycle_overrun", 64'(overrun), 0);
      end
      meas_ready = (cyc == c0 + 3);
    end
    meas_ready = 1'b1;
    rmode      = 0;
    run(0, 3);
    en = 1'b0;
    repeat (6) tick();
    check("drain_same_cycle", 64'(exp_q.size()), 0);

    // en dropped during HIGH: aborted period yields nothing, restart needs two rises.
    en = 1'b1;
    run(0, 4);
    run(1, 3);
    run(0, 5);
    push(3, 5);
    run(1, 5);
    en = 1'b0;
    run(1, 2);
    en = 1'b1;
    run(1, 2);
    run(0, 4);
    run(1, 3);
    run(0, 4);
    push(3, 4);
    run(1, 2);
    run(0, 3);
    en = 1'b0;
    repeat (8) tick();
    check("drain_en_toggle", 64'(exp_q.size()), 0);

    // Random run lengths with a randomly stalling consumer.
    rmode = 1;
    en    = 1'b1;
    run(0, 4);
    h = $urandom_range(1, 12);
    run(1, h);
    repeat (30) begin
      l = $urandom_range(1, 12);
      run(0, l);
      push(h, l);
      h = $urandom_range(1, 12);
      run(1, h);
    end
    run(0, 3);
    en = 1'b0;
    repeat (10) tick();
    check("drain_random", 64'(exp_q.size()), 0);
    check("random_overrun", 64'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
